alu_reg: RTL and testbench
==========================

// Module: alu_reg
// PURPOSE
//   Registered 4-function integer ALU: unsigned ADD, SUB, MUL, DIV.
//   Operands and opcode are sampled on the rising clock edge; the result is registered.
//   Sits in a datapath stage. Upstream holds operands/opcode stable; downstream reads out.
//   No handshake: a new operation is accepted every cycle.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>=2)
// PORTS
//   clk    in   1      single clock, rising-edge active
//   reset  in   1      asynchronous, active-low reset (0 = in reset)
//   A      in   WIDTH  operand A, unsigned
//   B      in   WIDTH  operand B, unsigned
//   S      in   2      opcode: 0=ADD 1=SUB 2=MUL 3=DIV
//   out    out  WIDTH  registered result
//   zero   out  1      registered; 1 when the result loaded into out is 0
//   carry  out  1      registered; ADD carry-out / SUB borrow; 0 for MUL/DIV
//   dz     out  1      registered; 1 when DIV executed with B==0
// BEHAVIOUR
//   Reset:
//     - reset=0 asynchronously forces out=0, zero=1, carry=0, dz=0 immediately.
//     - Outputs are held at these values while reset stays 0.
//     - The first update occurs at the first posedge with reset=1.
//     - Reset asserted mid-operation discards that result; no partial state remains.
//   Each posedge with reset=1, registers are loaded from the current A, B, S:
//     - S=0 ADD: {carry,out} = A + B (WIDTH+1-bit sum); out wraps modulo 2^WIDTH.
//     - S=1 SUB: out = (A - B) mod 2^WIDTH; carry = (A < B) as the borrow.
//     - S=2 MUL: out = low WIDTH bits of A*B; upper bits are discarded; carry = 0.
//     - S=3 DIV: out = floor(A / B), unsigned, combinational divider, no multicycle.
//       B==0 -> out = all ones, dz = 1; otherwise dz = 0.
//     - zero = (next out == 0). Computed from the value being loaded.
//   Latency and throughput:
//     - Latency is exactly 1 cycle: out reflects the inputs at the preceding posedge.
//     - Full throughput: one operation per cycle.
//     - Opcode or operand changes between edges have no effect until the next posedge.
//   Flags:
//     - All flags update every clock. dz is cleared by any non-DIV operation.
//   Divider timing:
//     - The divider must close timing at the target clock.
//     - If pipelining is ever added, WIDTH and latency become a spec change; not allowed here.
//   No X propagation: all outputs are driven from reset onward.
// TESTING
//   - Reset: hold reset=0 with A=6, B=3 and clocks running -> out=0, zero=1, carry=0, dz=0.
//   - Sequence A=6, B=3, S=0,1,2,3, one op per cycle after reset=1
//     -> out=9, 3, 18, 2 on consecutive cycles; each result is 1 cycle after its inputs.
//   - ADD wrap: A=32'hFFFFFFFF, B=1, S=0 -> out=0, zero=1, carry=1.
//   - SUB borrow: A=3, B=6, S=1 -> out=32'hFFFFFFFD, carry=1.
//   - MUL truncation: A=32'h10000, B=32'h10000 -> out=0, zero=1.
//     DIV: A=7, B=2 -> out=3, dz=0.
//   - Divide by zero: A=5, B=0, S=3 -> out=32'hFFFFFFFF, dz=1.
//     A next op (S=0, A=1, B=1) -> out=2, dz=0.
//     Then assert reset=0 between edges -> outputs clear immediately, without a clock.

Source files
------------

// File: rtl/alu_reg.sv
// alu_reg: registered 4-function unsigned integer ALU (ADD, SUB, MUL, DIV).
//
// The block samples the operands and the opcode on each rising clock edge and
// registers the result and the flags. Latency is one cycle, and the block
// accepts one operation per cycle. The divider is combinational.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous reset, active low (0 = in reset)
//   A, B   - unsigned operands, WIDTH bits
//   S      - opcode: 0=ADD 1=SUB 2=MUL 3=DIV
//   out    - registered result
//   zero   - registered; 1 when the loaded result is 0
//   carry  - registered; ADD carry-out or SUB borrow, 0 for MUL/DIV
//   dz     - registered; 1 when DIV executed with B==0
module alu_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             dz
);

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    op_t              op;
    logic [WIDTH-1:0] nxt_out;
    logic             nxt_carry;
    logic             nxt_dz;

    assign op = op_t'(S);

    always_comb begin
        nxt_out   = '0;
        nxt_carry = 1'b0;
        nxt_dz    = 1'b0;
        case (op)
            OP_ADD: {nxt_carry, nxt_out} = {1'b0, A} + {1'b0, B};
            OP_SUB: begin
                nxt_out   = A - B;
                nxt_carry = (A < B);
            end
            OP_MUL: nxt_out = A * B;
            OP_DIV: begin
                // A divide by zero saturates the result to all ones and
                // raises dz. The divider never sees B==0.
                if (B == '0) begin
                    nxt_out = '1;
                    nxt_dz  = 1'b1;
                end else begin
                    nxt_out = A / B;
                end
            end
            default: nxt_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out   <= '0;
            zero  <= 1'b1;
            carry <= 1'b0;
            dz    <= 1'b0;
        end else begin
            out   <= nxt_out;
            zero  <= (nxt_out == '0);
            carry <= nxt_carry;
            dz    <= nxt_dz;
        end
    end

endmodule

// File: tb/tb_alu_reg.sv
module tb_alu_reg;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   S;
    logic [W-1:0] out;
    logic         zero;
    logic         carry;
    logic         dz;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   s;
        logic [W-1:0] e_out;
        logic         e_zero;
        logic         e_carry;
        logic         e_dz;
    } vec_t;

    vec_t vecs[$];

    alu_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .S     (S),
        .out   (out),
        .zero  (zero),
        .carry (carry),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [W-1:0] e_out,
                             input logic e_zero, input logic e_carry, input logic e_dz);
        check({name, ".out"},   out,   e_out);
        check({name, ".zero"},  {{(W-1){1'b0}}, zero},  {{(W-1){1'b0}}, e_zero});
        check({name, ".carry"}, {{(W-1){1'b0}}, carry}, {{(W-1){1'b0}}, e_carry});
        check({name, ".dz"},    {{(W-1){1'b0}}, dz},    {{(W-1){1'b0}}, e_dz});
    endtask

    // Reference model: plain wide arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                         output logic [W-1:0] r, output logic z, output logic c, output logic d);
        longint unsigned la, lb, m, res;
        la  = longint'(a);
        lb  = longint'(b);
        m   = 64'd1 << W;
        c   = 1'b0;
        d   = 1'b0;
        res = 0;
        case (s)
            2'd0: begin res = (la + lb) % m; c = ((la + lb) >= m); end
            2'd1: begin res = (la + m - lb) % m; c = (la < lb); end
            2'd2: res = (la * lb) % m;
            default: begin
                if (lb == 0) begin res = m - 1; d = 1'b1; end
                else res = la / lb;
            end
        endcase
        r = res[W-1:0];
        z = (res == 0);
    endtask

    function automatic vec_t mk(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] s,
                                logic [W-1:0] eo, logic ez, logic ec, logic ed);
        vec_t v;
        v.a = a; v.b = b; v.s = s;
        v.e_out = eo; v.e_zero = ez; v.e_carry = ec; v.e_dz = ed;
        return v;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
        @(negedge clk);
        A = a; B = b; S = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] r;
        logic z, c, d;
        logic [W-1:0] ra, rb;
        logic [1:0] rs;

        vecs.push_back(mk(32'd6, 32'd3, 2'd0, 32'd9, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'd6, 32'd3, 2'd1, 32'd3, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'd6, 32'd3, 2'd2, 32'd18, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'd6, 32'd3, 2'd3, 32'd2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 2'd0, 32'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(32'd3, 32'd6, 2'd1, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(32'h10000, 32'h10000, 2'd2, 32'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(32'd7, 32'd2, 2'd3, 32'd3, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'd5, 32'd0, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(32'd1, 32'd1, 2'd0, 32'd2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'd0, 32'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(32'd5, 32'd5, 2'd1, 32'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(32'd0, 32'd1, 2'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(32'd0, 32'd0, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 32'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'd3, 32'd7, 2'd3, 32'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));

        // Hold reset low with operands present and clocks running.
        reset = 1'b0; A = 32'd6; B = 32'd3; S = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", 32'd0, 1'b1, 1'b0, 1'b0);

        // Release reset. The first posedge afterwards loads the first result.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_update", 32'd9, 1'b0, 1'b0, 1'b0);

        // Changing inputs between edges does not affect out until the next edge.
        A = 32'd100; B = 32'd1; S = 2'd1;
        #3;
        check_all("between_edges", 32'd9, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("after_edge", 32'd99, 1'b0, 1'b0, 1'b0);

        // Directed table, one operation per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].s);
            check_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_zero,
                      vecs[i].e_carry, vecs[i].e_dz);
        end

        // Divide by zero, then an ADD clears dz, then an asynchronous reset between edges.
        drive(32'd5, 32'd0, 2'd3);
        check_all("dz_set", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        drive(32'd1, 32'd1, 2'd0);
        check_all("dz_clear", 32'd2, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_all("async_reset", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = '1;
            rs = 2'($urandom_range(0, 3));
            drive(ra, rb, rs);
            model(ra, rb, rs, r, z, c, d);
            check_all($sformatf("rand%0d", i), r, z, c, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
